// File: rtl/mic_pre_pkg.sv
// Shared constants and helpers for the microphone pre-processing blocks.
package mic_pre_pkg;
    localparam int MIC_SAMPLE_W   = 32;
    localparam int MIC_TS_W       = 32;
    localparam int MIC_DROP_CNT_W = 16;

    function automatic logic [MIC_DROP_CNT_W-1:0] sat_inc_drop(input logic [MIC_DROP_CNT_W-1:0] cnt);
        if (cnt == {MIC_DROP_CNT_W{1'b1}}) begin
            sat_inc_drop = cnt;
        end else begin
            sat_inc_drop = cnt + {{(MIC_DROP_CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction
endpackage

// File: rtl/mic_fifo_ram.sv
// Simple dual-port storage for the sample FIFO: synchronous write, registered read.
module mic_fifo_ram #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem_r [0:(1<<ADDR_W)-1];

    // Storage array write port; left without reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register; holds the last read word until the next accepted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end
endmodule

// File: rtl/mic_sample_fifo.sv
// Timestamping sample FIFO behind the CIC decimator, with overflow accounting.
module mic_sample_fifo
    import mic_pre_pkg::*;
#(
    parameter int DATA_W     = MIC_SAMPLE_W,
    parameter int TS_W       = MIC_TS_W,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  data_in_valid,
    input  logic                  flush,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_sample,
    output logic [TS_W-1:0]       rd_timestamp,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [15:0]           drop_cnt
);
    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [TS_W-1:0]  TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0]          wptr_r, rptr_r, level_r;
    logic [PTR_W-1:0]          wptr_nxt_s, rptr_nxt_s;
    logic                      empty_r, full_r, full_nxt_s, empty_nxt_s;
    logic                      rd_valid_r, overflow_r;
    logic [MIC_DROP_CNT_W-1:0] drop_cnt_r;
    logic [TS_W-1:0]           ts_cnt_r;
    logic                      wr_ok_s, rd_ok_s, drop_s;
    logic [DATA_W+TS_W-1:0]    ram_rd_data_s;

    // Accept/drop decisions use the status registered at the start of the cycle.
    always_comb begin
        wr_ok_s    = data_in_valid & ~full_r;
        rd_ok_s    = rd_en & ~empty_r;
        drop_s     = data_in_valid & full_r;
        wptr_nxt_s = wr_ok_s ? (wptr_r + PTR_ONE) : wptr_r;
        rptr_nxt_s = rd_ok_s ? (rptr_r + PTR_ONE) : rptr_r;
        empty_nxt_s = (wptr_nxt_s == rptr_nxt_s);
        full_nxt_s  = (wptr_nxt_s[DEPTH_LOG2] != rptr_nxt_s[DEPTH_LOG2]) &&
                      (wptr_nxt_s[DEPTH_LOG2-1:0] == rptr_nxt_s[DEPTH_LOG2-1:0]);
    end

    // Pointers, status, overflow tracking and the free-running timestamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r     <= '0;
            rptr_r     <= '0;
            level_r    <= '0;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            overflow_r <= 1'b0;
            drop_cnt_r <= '0;
            ts_cnt_r   <= '0;
        end else begin
            ts_cnt_r <= ts_cnt_r + TS_ONE;
            if (flush) begin
                wptr_r     <= '0;
                rptr_r     <= '0;
                level_r    <= '0;
                empty_r    <= 1'b1;
                full_r     <= 1'b0;
                rd_valid_r <= 1'b0;
                overflow_r <= 1'b0;
                drop_cnt_r <= '0;
            end else begin
                wptr_r     <= wptr_nxt_s;
                rptr_r     <= rptr_nxt_s;
                level_r    <= wptr_nxt_s - rptr_nxt_s;
                empty_r    <= empty_nxt_s;
                full_r     <= full_nxt_s;
                rd_valid_r <= rd_ok_s;
                if (drop_s) begin
                    overflow_r <= 1'b1;
                    drop_cnt_r <= sat_inc_drop(drop_cnt_r);
                end else begin
                    overflow_r <= overflow_r;
                    drop_cnt_r <= drop_cnt_r;
                end
            end
        end
    end

    // Each entry packs the timestamp above the sample word.
    mic_fifo_ram #(
        .WIDTH  (DATA_W + TS_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok_s & ~flush),
        .wr_addr (wptr_r[DEPTH_LOG2-1:0]),
        .wr_data ({ts_cnt_r, data_in}),
        .rd_en   (rd_ok_s & ~flush),
        .rd_addr (rptr_r[DEPTH_LOG2-1:0]),
        .rd_data (ram_rd_data_s)
    );

    assign rd_sample    = ram_rd_data_s[DATA_W-1:0];
    assign rd_timestamp = ram_rd_data_s[DATA_W+TS_W-1:DATA_W];
    assign rd_valid     = rd_valid_r;
    assign empty        = empty_r;
    assign full         = full_r;
    assign level        = level_r;
    assign overflow     = overflow_r;
    assign drop_cnt     = drop_cnt_r;
endmodule

// File: tb/tb_mic_sample_fifo.sv
// Scoreboard bench for mic_sample_fifo: directed stimulus, read data checked by a monitor.
module tb_mic_sample_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        data_in_valid, flush, rd_en;
    logic [31:0] rd_sample, rd_timestamp;
    logic        rd_valid, empty, full, overflow;
    logic [5:0]  level;
    logic [15:0] drop_cnt;

    logic [7:0]  w_data;
    logic        w_valid, w_rd, w_flush;
    logic [7:0]  w_rd_sample;
    logic [3:0]  w_rd_ts;
    logic        w_rd_valid, w_empty, w_full, w_ovf;
    logic [2:0]  w_level;
    logic [15:0] w_drop;

    typedef struct packed { logic [31:0] d; logic [31:0] ts; } ent_t;
    ent_t m_fifo[$];
    ent_t exp_q[$];
    int   m_drop;
    bit   m_ovf;
    int   cyc;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mic_sample_fifo u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .flush(flush), .rd_en(rd_en), .rd_sample(rd_sample), .rd_timestamp(rd_timestamp),
        .rd_valid(rd_valid), .empty(empty), .full(full), .level(level),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    mic_sample_fifo #(.DATA_W(8), .TS_W(4), .DEPTH_LOG2(2)) u_wrap (
        .clk(clk), .rst(rst), .data_in(w_data), .data_in_valid(w_valid),
        .flush(w_flush), .rd_en(w_rd), .rd_sample(w_rd_sample), .rd_timestamp(w_rd_ts),
        .rd_valid(w_rd_valid), .empty(w_empty), .full(w_full), .level(w_level),
        .overflow(w_ovf), .drop_cnt(w_drop)
    );

    // Monitor: every rd_valid pulse must match the oldest expected read.
    always @(negedge clk) begin
        ent_t e;
        if (!rst && rd_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: rd_valid=1 sample=%h with no read pending", rd_sample);
            end else begin
                e = exp_q.pop_front();
                if (rd_sample !== e.d || rd_timestamp !== e.ts) begin
                    bad++;
                    $display("FAIL rd_data: got sample=%h ts=%0d, want sample=%h ts=%0d",
                             rd_sample, rd_timestamp, e.d, e.ts);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string name);
        chk({name, "_level"}, 32'(level), 32'(m_fifo.size()));
        chk({name, "_empty"}, 32'(empty), 32'(m_fifo.size() == 0));
        chk({name, "_full"}, 32'(full), 32'(m_fifo.size() == 32));
        chk({name, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({name, "_drop"}, 32'(drop_cnt), 32'(m_drop));
    endtask

    // One clock of stimulus; the model is updated from the state before the edge.
    task automatic step(input logic wv, input logic [31:0] d, input logic re, input logic fl);
        ent_t e;
        bit was_full, was_empty;
        data_in_valid = wv; data_in = d; rd_en = re; flush = fl;
        if (fl) begin
            m_fifo.delete(); m_ovf = 1'b0; m_drop = 0;
        end else begin
            was_full  = (m_fifo.size() == 32);
            was_empty = (m_fifo.size() == 0);
            if (re && !was_empty) exp_q.push_back(m_fifo.pop_front());
            if (wv) begin
                if (was_full) begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end else begin
                    e.d = d; e.ts = 32'(cyc);
                    m_fifo.push_back(e);
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        data_in_valid = 1'b0; rd_en = 1'b0; flush = 1'b0;
    endtask

    task automatic idle_until(input int c);
        while (cyc < c) step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_rd_valid"}, 32'(rd_valid), 32'h0);
        chk({name, "_rd_sample"}, rd_sample, 32'h0);
        chk({name, "_rd_ts"}, rd_timestamp, 32'h0);
        chk({name, "_empty"}, 32'(empty), 32'h1);
        chk({name, "_full"}, 32'(full), 32'h0);
        chk({name, "_level"}, 32'(level), 32'h0);
        chk({name, "_ovf"}, 32'(overflow), 32'h0);
        chk({name, "_drop"}, 32'(drop_cnt), 32'h0);
    endtask

    initial begin
        rst = 1'b1; data_in = 32'h0; data_in_valid = 1'b0; flush = 1'b0; rd_en = 1'b0;
        w_data = 8'h0; w_valid = 1'b0; w_rd = 1'b0; w_flush = 1'b0;
        m_drop = 0; m_ovf = 1'b0; cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #2 rst = 1'b0;
        cyc = 0;

        // Three spaced samples, timestamps 10/20/30 from reset release.
        idle_until(10); step(1'b1, 32'h11, 1'b0, 1'b0);
        idle_until(20); step(1'b1, 32'h22, 1'b0, 1'b0);
        idle_until(30); step(1'b1, 32'h33, 1'b0, 1'b0);
        chk("three_level", 32'(level), 32'd3);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            chk("three_rd_valid", 32'(rd_valid), 32'h1);
        end
        chk_status("three_drained");
        chk("three_empty", 32'(empty), 32'h1);

        // Fill to full, then three dropped writes.
        for (int i = 0; i < 32; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_level", 32'(level), 32'd32);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_drop3", 32'(drop_cnt), 32'd3);
        chk_status("ovf");

        // Simultaneous read and write when full: read wins, write dropped.
        step(1'b1, 32'hDEAD, 1'b1, 1'b0);
        chk("fullrw_level", 32'(level), 32'd31);
        chk("fullrw_drop", 32'(drop_cnt), 32'd4);
        for (int i = 0; i < 31; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk_status("drained32");

        // Simultaneous read and write when empty: write stored, read ignored.
        step(1'b1, 32'hAB, 1'b1, 1'b0);
        chk("emptyrw_rd_valid", 32'(rd_valid), 32'h0);
        chk("emptyrw_level", 32'(level), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk_status("ab_read");

        // Flush with a concurrent write: nothing stored, status cleared.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        chk("preflush_level", 32'(level), 32'd5);
        chk("preflush_ovf", 32'(overflow), 32'h1);
        step(1'b1, 32'hEE, 1'b0, 1'b1);
        chk_status("flush");
        chk("flush_rd_valid", 32'(rd_valid), 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h77, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk_status("postflush");

        // Asynchronous reset between edges, with a read in flight.
        step(1'b1, 32'h400, 1'b0, 1'b0);
        step(1'b1, 32'h401, 1'b0, 1'b0);
        step(1'b1, 32'h402, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete(); m_fifo.delete(); m_ovf = 1'b0; m_drop = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_rd_valid", 32'(rd_valid), 32'h0);
        #1 rst = 1'b0;
        cyc = 0;

        // Timestamp wrap on a 4-bit-counter instance: 15 then 0.
        idle_until(15);
        w_valid = 1'b1; w_data = 8'h5A;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        w_data = 8'h5B;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        w_valid = 1'b0; w_rd = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("wrap_rv0", 32'(w_rd_valid), 32'h1);
        chk("wrap_d0", 32'(w_rd_sample), 32'h5A);
        chk("wrap_ts15", 32'(w_rd_ts), 32'd15);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        w_rd = 1'b0;
        chk("wrap_d1", 32'(w_rd_sample), 32'h5B);
        chk("wrap_ts0", 32'(w_rd_ts), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mic_sample_fifo.md
Name: mic_sample_fifo

Overview:
- Sits directly downstream of the microphone CIC decimator and buffers its decimated output samples for the processor-side bus logic.
- Each accepted sample is tagged with a free-running clk-cycle timestamp, so software can align channels for time-of-arrival estimation.
- Provides a registered read handshake, fill level, and a sticky overflow indication with a dropped-sample counter.

Parameters:
- DATA_W, 32, sample width; matches the CIC output word.
- TS_W, 32, timestamp counter width.
- DEPTH_LOG2, 5, log2 of FIFO depth; the default gives 32 entries.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset, asynchronous, active-high
- data_in  in  DATA_W  sample from the CIC filter
- data_in_valid  in  1  one-cycle strobe; data_in is valid on this cycle
- flush  in  1  synchronous clear of FIFO contents and status
- rd_en  in  1  read request from the consumer
- rd_sample  out  DATA_W  read sample
- rd_timestamp  out  TS_W  timestamp of the read sample
- rd_valid  out  1  one-cycle strobe; rd_sample and rd_timestamp are valid
- empty  out  1  FIFO holds 0 entries
- full  out  1  FIFO holds 2^DEPTH_LOG2 entries
- level  out  DEPTH_LOG2+1  current entry count
- overflow  out  1  sticky; set when a sample was dropped
- drop_cnt  out  16  count of dropped samples, saturates at 16'hFFFF

Behaviour:
- Reset (async, rst=1):
  - rd_sample=0, rd_timestamp=0, rd_valid=0.
  - empty=1, full=0, level=0, overflow=0, drop_cnt=0.
  - Write and read pointers = 0; timestamp counter = 0.
  - RAM contents undefined.
  - Reset mid-operation discards all entries; an in-flight rd_valid is suppressed.
- Timestamp counter:
  - Increments every clk cycle and wraps modulo 2^TS_W.
  - Not affected by flush.
- Write:
  - On data_in_valid=1 and full=0, store {counter value in that same cycle, data_in} at wptr; wptr advances modulo depth.
  - On data_in_valid=1 and full=1, the sample is dropped: overflow<=1; drop_cnt increments unless already saturated.
- Read:
  - On rd_en=1 and empty=0, the entry at rptr is registered onto rd_sample/rd_timestamp; rd_valid=1 on the following cycle (latency 1); rptr advances.
  - On rd_en=1 and empty=1, the request is ignored: rd_valid=0 next cycle, outputs hold their last values.
  - rd_sample and rd_timestamp hold their values until the next successful read.
- Status:
  - full and empty are evaluated on the registered state at the start of the cycle.
  - Simultaneous write and read when full: the read succeeds and the write is dropped (counted as overflow).
  - Simultaneous write and read when empty: the write succeeds and the read is ignored.
  - Simultaneous write and read otherwise: both occur; level is unchanged.
  - level, empty and full are registered and update in the cycle after the write or read.
  - Pointers are DEPTH_LOG2+1 bits wide with a wrap bit: full when the MSBs differ and the LSBs are equal.
- Flush:
  - Synchronous. Takes priority over write and read in the same cycle.
  - Clears the pointers, level, overflow, drop_cnt and rd_valid.
  - The timestamp counter and rd_sample/rd_timestamp data are retained.
- Throughput: one write per cycle is supported, far exceeding the CIC output rate; no backpressure is applied upstream.

Decomposition:
- Shared package mic_pre_pkg: MIC_SAMPLE_W=32, MIC_TS_W=32, MIC_DROP_CNT_W=16.
- Sub-module mic_fifo_ram: simple dual-port RAM, 2^DEPTH_LOG2 x (DATA_W+TS_W).
  - Synchronous write; registered read.
  - Inferable as block or distributed RAM.
- Top level holds the pointers, status logic, timestamp counter and overflow logic.

Test Plan:
- Reset, then write samples 0x11, 0x22, 0x33 at cycles 10, 20, 30; read all three → rd_sample 0x11/0x22/0x33 in order, rd_timestamp 10/20/30 (cycles counted from reset release), rd_valid one cycle after each rd_en, level 3→0, empty=1 at the end.
- Write 32 samples with no reads → full=1, level=32. Then write 3 more → overflow=1, drop_cnt=3, and reading 32 entries returns only the first 32 samples.
- With full=1, assert data_in_valid and rd_en in the same cycle → one entry is read, the write is dropped, drop_cnt increments, level=31.
- With empty=1, assert rd_en and data_in_valid 0xAB in the same cycle → rd_valid=0 next cycle, level=1; a later read returns 0xAB.
- Fill 5 entries with overflow set, then pulse flush together with data_in_valid → level=0, empty=1, overflow=0, drop_cnt=0, the sample is not stored, and the timestamp counter keeps running.
- Assert rst asynchronously mid-burst (between clock edges) → all outputs take their reset values immediately and rd_valid stays 0. Force the timestamp counter to 2^TS_W−1 and write → the next sample's timestamp wraps to 0.
